mem_responder: RTL and testbench

- Unified instruction/data memory slave that sits opposite the multi-cycle RISC-V datapath on its memory interface.
- Accepts one word-addressed read or write request at a time and inserts a programmable number of wait states.
- Returns read data or write completion with a one-cycle ready pulse.
- Flags misaligned or out-of-range accesses instead of performing them.

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 139 +++++++++++++
 tb/tb_mem_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath memory port and mem_responder.
// The master drives one request; the slave answers with a single-cycle ready pulse.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory slave. Takes one word-addressed
// read or write at a time, waits LATENCY cycles, then answers with a one-cycle
// ready pulse. Misaligned or out-of-range accesses are flagged with err and are
// never performed. Response outputs are registered on the edge that ends RESP.
module mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [3:0]  LATENCY_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic [31:0] mem [DEPTH];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        fault;

  // An access is refused when the offset is not word aligned or lands past the
  // last stored word; the offset wraps, so addresses below BASE are refused too.
  function automatic logic addr_fault(input logic [31:0] offset);
    addr_fault = (offset[1:0] != 2'b00) || (|offset[31:AW+2]);
  endfunction

  // Decode is done from the captured address only, so later bus changes are inert.
  assign off   = cap_addr - BASE;
  assign idx   = off[AW+1:2];
  assign fault = addr_fault(off);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, count wait states, one RESP cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          state_next = (LATENCY == 32'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt <= 4'd1) begin
          state_next = ST_RESP;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the request at acceptance and run the wait-state counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'h0000_0000;
      cap_wdata <= 32'h0000_0000;
      cap_be    <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            cnt       <= LATENCY_CNT;
            cap_we    <= bus.we;
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
            cap_be    <= bus.be;
          end else begin
            cnt <= cnt;
          end
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Commit enabled write bytes on the edge that ends RESP. The array has no
  // reset; an async reset forces IDLE, so an uncommitted write is dropped.
  always_ff @(posedge clk) begin
    if ((state == ST_RESP) && cap_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_be[i]) begin
          mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered response: ready/err/rdata pulse for one cycle, zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata <= 32'h0000_0000;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      bus.busy <= (state_next != ST_IDLE);
      if (state == ST_RESP) begin
        bus.ready <= 1'b1;
        bus.err   <= fault;
        bus.rdata <= (!fault && !cap_we) ? mem[idx] : 32'h0000_0000;
      end else begin
        bus.ready <= 1'b0;
        bus.err   <= 1'b0;
        bus.rdata <= 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, random traffic against a
// word-array reference model, reset abort, captured-request and streaming cases.
// Instance 0: DEPTH=256, LATENCY=2, BASE=0. Instance 1: DEPTH=16, LATENCY=0, BASE=0x1000.
module tb_mem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if b2 ();
  mem_responder_if b0 ();

  mem_responder #(.DEPTH(256), .LATENCY(2), .BASE(32'h0000_0000)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave));
  mem_responder #(.DEPTH(16), .LATENCY(0), .BASE(32'h0000_1000)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave));

  int n_pass  = 0;
  int n_total = 0;

  bit [31:0] mdl2 [256];
  bit [31:0] mdl0 [16];

  typedef struct {
    string     name;
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    bit        exp_err;
    bit [31:0] exp_rd;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input int sel, input logic rq, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b);
    if (sel == 1) begin
      b0.req = rq; b0.we = w; b0.addr = a; b0.wdata = wd; b0.be = b;
    end else begin
      b2.req = rq; b2.we = w; b2.addr = a; b2.wdata = wd; b2.be = b;
    end
  endtask

  task automatic sample(input int sel, output logic rdy, output logic er,
                        output logic [31:0] d, output logic bsy);
    if (sel == 1) begin
      rdy = b0.ready; er = b0.err; d = b0.rdata; bsy = b0.busy;
    end else begin
      rdy = b2.ready; er = b2.err; d = b2.rdata; bsy = b2.busy;
    end
  endtask

  // Reference model: memory as a plain word array, offset arithmetic from BASE.
  function automatic void model(input int sel, input bit we, input bit [31:0] addr,
                                input bit [31:0] wdata, input bit [3:0] be,
                                output bit exp_err, output bit [31:0] exp_rd);
    bit [31:0]   base;
    bit [31:0]   off;
    int unsigned depth;
    int unsigned word;
    bit [31:0]   cur;
    base    = (sel == 1) ? 32'h0000_1000 : 32'h0000_0000;
    depth   = (sel == 1) ? 16 : 256;
    off     = addr - base;
    word    = off / 4;
    exp_err = ((off % 4) != 0) || (word >= depth);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      cur = (sel == 1) ? mdl0[word] : mdl2[word];
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
        if (sel == 1) mdl0[word] = cur; else mdl2[word] = cur;
      end else begin
        exp_rd = cur;
      end
    end
  endfunction

  // One transaction from an idle DUT, starting just after a rising edge. Checks
  // latency (ready LATENCY+1 cycles after the accept edge), busy and pulse width.
  task automatic txn(input int sel, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input bit scramble,
                     output logic [31:0] rd, output logic er);
    int lat = -1;
    int lmax = (sel == 1) ? 0 : 2;
    logic rdy, e, b;
    logic [31:0] d;
    rd = 32'h0;
    er = 1'b0;
    drive(sel, 1'b1, we, addr, wdata, be);
    @(posedge clk); #1;
    if (scramble) drive(sel, 1'b0, ~we, $urandom(), $urandom(), 4'($urandom()));
    else drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      sample(sel, rdy, e, d, b);
      if (k == 1) check("busy_after_accept", 32'(b), 32'd1);
      if (rdy) begin
        lat = k - 1;
        rd  = d;
        er  = e;
        check("busy_at_ready", 32'(b), 32'd0);
        break;
      end
    end
    check("latency", 32'(lat), 32'(lmax + 1));
    @(negedge clk);
    sample(sel, rdy, e, d, b);
    check("ready_pulse_width", 32'(rdy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic add(input string n, input bit w, input bit [31:0] a, input bit [31:0] wd,
                     input bit [3:0] b, input bit ee, input bit [31:0] er);
    vec_t v;
    v.name = n; v.we = w; v.addr = a; v.wdata = wd; v.be = b; v.exp_err = ee; v.exp_rd = er;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        rdy, e, b;
    logic [31:0] d;
    bit          m_err;
    bit [31:0]   m_rd;
    bit          seen;
    bit          s_we [6];
    bit [31:0]   s_addr [6];
    bit [31:0]   s_wd [6];
    bit [31:0]   s_exp [6];

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state of both instances.
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, rdy, e, d, b);
      check("reset_ready", 32'(rdy), 32'd0);
      check("reset_err", 32'(e), 32'd0);
      check("reset_rdata", d, 32'h0);
      check("reset_busy", 32'(b), 32'd0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Known contents for words 0..15 of the LATENCY=2 instance.
    for (int i = 0; i < 16; i++) begin
      bit [31:0] v;
      v = $urandom();
      model(0, 1'b1, 32'(i * 4), v, 4'hF, m_err, m_rd);
      txn(0, 1'b1, 32'(i * 4), v, 4'hF, 1'b0, rd, er);
      check("init_err", 32'(er), 32'(m_err));
    end

    // Directed vector table.
    add("full_write",       1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0);
    add("read_back",        1'b0, 32'h0000_0010, 32'h0,         4'h0,    1'b0, 32'hDEAD_BEEF);
    add("partial_write",    1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, 1'b0, 32'h0);
    add("partial_read",     1'b0, 32'h0000_0010, 32'h0,         4'h0,    1'b0, 32'hDEAD_AAEF);
    add("misaligned_read",  1'b0, 32'h0000_0012, 32'h0,         4'h0,    1'b1, 32'h0);
    add("last_word_write",  1'b1, 32'h0000_03FC, 32'h1122_3344, 4'hF,    1'b0, 32'h0);
    add("oor_write",        1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF,    1'b1, 32'h0);
    add("last_word_intact", 1'b0, 32'h0000_03FC, 32'h0,         4'h0,    1'b0, 32'h1122_3344);
    add("clear_0x20",       1'b1, 32'h0000_0020, 32'h0,         4'hF,    1'b0, 32'h0);
    add("be_zero_write",    1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0,    1'b0, 32'h0);
    add("be_zero_read",     1'b0, 32'h0000_0020, 32'h0,         4'h0,    1'b0, 32'h0);
    add("misaligned_write", 1'b1, 32'h0000_0021, 32'h5555_5555, 4'hF,    1'b1, 32'h0);
    add("far_oor_read",     1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    1'b1, 32'h0);
    add("low_byte_write",   1'b1, 32'h0000_0010, 32'h0000_0077, 4'b0001, 1'b0, 32'h0);
    add("low_byte_read",    1'b0, 32'h0000_0010, 32'h0,         4'h0,    1'b0, 32'hDEAD_AA77);
    foreach (vt[i]) begin
      model(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, m_err, m_rd);
      txn(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, 1'b0, rd, er);
      check({vt[i].name, "_err"}, 32'(er), 32'(vt[i].exp_err));
      check({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
    end

    // Reset during WAIT of a write: no ready afterwards, memory untouched.
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("wait_busy", 32'(b2.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(b2.busy), 32'd0);
    check("abort_ready", 32'(b2.ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (b2.ready) seen = 1'b1;
    end
    check("no_ready_after_abort", 32'(seen), 32'd0);
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, rd, er);
    check("aborted_write_lost", rd, 32'h0);

    // Bus changes during WAIT do not affect the captured request.
    model(0, 1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 4'hF, m_err, m_rd);
    txn(0, 1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 4'hF, 1'b1, rd, er);
    check("captured_write_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h0000_0024, 32'h0, 4'h0, 1'b1, rd, er);
    check("captured_read", rd, 32'hA5A5_A5A5);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      int unsigned r;
      bit          w;
      bit [31:0]   a, wd;
      bit [3:0]    bb;
      bit          scr;
      r  = $urandom_range(0, 9);
      w  = 1'($urandom_range(0, 1));
      wd = $urandom();
      bb = 4'($urandom());
      scr = 1'($urandom_range(0, 1));
      if (r <= 6) a = 32'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'((256 + $urandom_range(0, 1000)) * 4);
      else a = 32'h0000_03FC;
      model(0, w, a, wd, bb, m_err, m_rd);
      txn(0, w, a, wd, bb, scr, rd, er);
      check("rand_err", 32'(er), 32'(m_err));
      check("rand_rdata", rd, m_rd);
    end

    // LATENCY=0 instance with req held high: writes then reads, one every 2 cycles.
    s_we[0] = 1'b1; s_addr[0] = 32'h0000_1000; s_wd[0] = 32'h0BAD_F00D;
    s_we[1] = 1'b1; s_addr[1] = 32'h0000_1004; s_wd[1] = 32'h1357_9BDF;
    s_we[2] = 1'b1; s_addr[2] = 32'h0000_103C; s_wd[2] = 32'h2468_ACE0;
    s_we[3] = 1'b0; s_addr[3] = 32'h0000_1000; s_wd[3] = 32'h0;
    s_we[4] = 1'b0; s_addr[4] = 32'h0000_1004; s_wd[4] = 32'h0;
    s_we[5] = 1'b0; s_addr[5] = 32'h0000_103C; s_wd[5] = 32'h0;
    for (int j = 0; j < 6; j++) model(1, s_we[j], s_addr[j], s_wd[j], 4'hF, m_err, s_exp[j]);
    drive(1, 1'b1, s_we[0], s_addr[0], s_wd[0], 4'hF);
    for (int ed = 0; ed < 12; ed++) begin
      @(posedge clk); #1;
      if (ed % 2 == 0) begin
        if (ed / 2 + 1 < 6) drive(1, 1'b1, s_we[ed/2+1], s_addr[ed/2+1], s_wd[ed/2+1], 4'hF);
        else drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      @(negedge clk);
      sample(1, rdy, e, d, b);
      check("stream_busy", 32'(b), 32'(ed % 2 == 0));
      check("stream_ready", 32'(rdy), 32'(ed % 2 == 1));
      if (ed % 2 == 1) begin
        check("stream_err", 32'(e), 32'd0);
        check("stream_rdata", d, s_exp[ed/2]);
      end
    end
    @(posedge clk); #1;

    // LATENCY=0 boundaries: below BASE wraps to out-of-range, one past the end.
    txn(1, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, 1'b0, rd, er);
    check("below_base_err", 32'(er), 32'd1);
    txn(1, 1'b1, 32'h0000_1040, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
    check("past_end_err", 32'(er), 32'd1);
    txn(1, 1'b0, 32'h0000_103C, 32'h0, 4'h0, 1'b0, rd, er);
    check("last_word_l0", rd, 32'h2468_ACE0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
